nand_sweep_checker: RTL

Self-checking stimulus/response sequencer for the 2-input NAND sample component. On `start` it drives every input vector onto the component's `a` port in ascending order, lets each vector settle, samples the component's `c` output, and compares it against the expected NAND value. It reports the mismatch count, the first failing vector and a pass/done verdict. It sits beside the component under test and replaces the hand-driven stimulus sweep with a synthesizable checker.

---
 rtl/nand_sweep_checker_if.sv | 26 ++
 rtl/nand_sweep_checker.sv | 99 +++++++++
 2 files changed

// File: rtl/nand_sweep_checker_if.sv
// Bundle between the sweep checker and the logic that launches it and hosts the
// NAND component under test. The master launches sweeps and returns the component output.
interface nand_sweep_checker_if #(
  parameter int WIDTH = 2,
  parameter int ERR_W = 4
);
  logic             start;
  logic             dut_c;
  logic [WIDTH-1:0] stim_a;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] first_fail_vec;
  logic             first_fail_valid;

  modport master (
    output start, dut_c,
    input  stim_a, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  modport slave (
    input  start, dut_c,
    output stim_a, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );
endinterface

// File: rtl/nand_sweep_checker.sv
// Drives every input vector into a 2-input NAND component, lets it settle, and
// compares the sampled output against the expected NAND value, keeping a verdict.
module nand_sweep_checker #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 2,  // must be at least 1
  parameter int ERR_W  = 4
) (
  input logic             clk,
  input logic             rst_n,
  nand_sweep_checker_if.slave bus
);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] LAST_VEC = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK} state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [WIDTH-1:0] stim_q;
  logic [WIDTH-1:0] ffv_q;
  logic [ERR_W-1:0] err_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             ffvalid_q;
  logic             mismatch;

  assign mismatch = (bus.dut_c != ~&stim_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      stim_q     <= '0;
      ffv_q      <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      ffvalid_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_SETTLE;
            stim_q     <= '0;
            busy_q     <= 1'b1;
            settle_cnt <= '0;
            err_q      <= '0;
            ffvalid_q  <= 1'b0;
            ffv_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_q <= err_q + ERR_W'(1);
            end
            if (!ffvalid_q) begin
              ffv_q     <= stim_q;
              ffvalid_q <= 1'b1;
            end
          end
          // The verdict must include the compare happening on this same edge.
          if (stim_q != LAST_VEC) begin
            stim_q     <= stim_q + WIDTH'(1);
            settle_cnt <= '0;
            state      <= S_SETTLE;
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_q == '0) && !mismatch;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.stim_a           = stim_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_vec   = ffv_q;
  assign bus.first_fail_valid = ffvalid_q;
endmodule
